mem_lsu: RTL
============

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit address/data, 4-bit byte mask, 5-bit tag.
REQ-002 clk  in  1  single clock; every state element SHALL update on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  core presents a load/store request.
REQ-005 req_ready  out  1  block accepts the request this cycle.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  RV32I width/sign code: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-aligned.
REQ-010 req_rd  in  5  destination tag, returned with the load response.
REQ-011 mem_addr  out  32  to the data-memory port address.
REQ-012 mem_wmask  out  4  to the data-memory port byte write enables.
REQ-013 mem_wdata  out  32  to the data-memory port, lane-replicated store data.
REQ-014 mem_data  in  32  registered read data; valid one cycle after the address is presented.
REQ-015 rsp_valid  out  1  load response pending.
REQ-016 rsp_ready  in  1  consumer takes the response.
REQ-017 rsp_data  out  32  aligned, extended load result.
REQ-018 rsp_rd  out  5  tag of the responding load.
REQ-019 rsp_err  out  1  response belongs to a misaligned or illegal load.
REQ-020 store_err  out  1  one-cycle pulse, registered, for a misaligned or illegal store.

Function
REQ-021 A request SHALL be accepted when req_valid && req_ready.
REQ-022 req_ready SHALL equal !p1_valid || slot_free, where slot_free = !rsp_valid || rsp_ready.
REQ-023 On acceptance, mem_addr SHALL equal req_addr in the same cycle; otherwise mem_addr SHALL equal the p1 address.
REQ-024 mem_wmask SHALL be nonzero only in the cycle a legal, aligned store is accepted, and SHALL be 0 whenever reset=1.
REQ-025 Store mask: SB = 0001<<addr[1:0]; SH = 0011<<addr[1:0]; SW = 1111.
REQ-026 Store data: SB replicates the byte x4; SH replicates the halfword x2; SW passes through unchanged.
REQ-027 Stores SHALL complete in the accept cycle and SHALL produce no response.
REQ-028 An accepted load SHALL set p1_valid, holding address, funct3 and rd, on the following edge.
REQ-029 When p1_valid && slot_free, the formatted mem_data SHALL load into the rsp registers; rsp_valid rises two cycles after acceptance.
REQ-030 When p1_valid && !slot_free (stall), p1 SHALL hold, mem_addr SHALL stay at the p1 address with mask 0, and mem_data SHALL be re-read each cycle.
REQ-031 A simultaneous p1-to-rsp transfer and new acceptance SHALL occur in the same cycle, giving one load per cycle throughput.
REQ-032 rsp_valid && !rsp_ready SHALL hold all rsp outputs stable.
REQ-033 Load format: LB/LBU select byte addr[1:0]; LH/LHU select halfword addr[1]; B/H sign-extend, BU/HU zero-extend.
REQ-034 Misalignment: H/HU with addr[0]=1, or W with addr[1:0]!=0. Illegal: load funct3 011/110/111, or store funct3 >=011.
REQ-035 An erroneous load SHALL return rsp_err=1 and rsp_data=0 with normal latency.
REQ-036 An erroneous store SHALL write nothing and SHALL pulse store_err on the next cycle.
REQ-037 A store accepted at cycle N+1 SHALL NOT affect the result of a load accepted at cycle N.

Reset
REQ-038 Reset SHALL clear p1_valid, rsp_valid, rsp_data, rsp_rd, rsp_err and store_err to 0.
REQ-039 Reset during an in-flight or stalled load SHALL discard that load with no response.
REQ-040 During reset, req_ready SHALL be 0.

Structure
REQ-041 Shared package lsu_pkg SHALL hold the funct3 constants and the request/response struct typedefs.
REQ-042 One combinational sub-module, lsu_align, SHALL implement the store mask/replication and the load extraction/extension.

Verification
REQ-043 Test: RAM[0x100]=0x8081_82F3; LB at 0x100 -> 0xFFFF_FFF3; LBU at 0x101 -> 0x0000_0082; LH at 0x102 -> 0xFFFF_8081.
REQ-044 Test: SB 0x12 at 0x203 -> mem_wmask=1000, mem_wdata=0x1212_1212; then LW at 0x200 -> 0x12xx_xxxx.
REQ-045 Test: back-to-back LWs at 0x0, 0x4, 0x8 with rsp_ready=1 -> three responses on consecutive cycles, tags in order.
REQ-046 Test: rsp_ready=0 for 3 cycles with two loads issued -> req_ready=0, mem_wmask=0, rsp held, no loss or duplication.
REQ-047 Test: LW at 0x102 -> rsp_err=1, rsp_data=0; SH at 0x301 -> no write, store_err pulse.
REQ-048 Test: reset asserted while a load is stalled -> all outputs 0 next cycle; a subsequent load behaves normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the RV32I funct3 width codes, the request/pipeline/response
// record types, and the legality checks that both the top and the
// alignment datapath need.
package lsu_pkg;

  // RV32I width/sign codes (loads and stores share B/H/W)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Request as presented by the core
  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } lsu_req_t;

  // Load waiting for its read data
  typedef struct packed {
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [4:0]  rd;
  } lsu_p1_t;

  // Load result handed to the consumer
  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
  } lsu_rsp_t;

  // A load is bad when its width code is unknown or the address is not
  // naturally aligned for that width.
  function automatic logic ldBad(input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    bad = 1'b1;
    case (f3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = lo[0];
      F3_W:        bad = (lo != 2'b00);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Stores only have B/H/W; anything from 011 upward is illegal.
  function automatic logic stBad(input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    bad = 1'b1;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = lo[0];
      F3_W:    bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Bundle of all handshake and bus signals around the load/store unit:
// core request channel, data-memory port and load response channel.
//   slave  : the LSU itself (takes requests, drives the memory port,
//            produces responses)
//   master : the surrounding system (core, data memory, consumer)
interface mem_lsu_if;

  // Core request channel
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  // Data-memory port (mem_data is registered, one cycle after mem_addr)
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_data;

  // Load response channel and store error pulse
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_err;
  logic        store_err;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    input  mem_data, rsp_ready,
    output req_ready, mem_addr, mem_wmask, mem_wdata,
    output rsp_valid, rsp_data, rsp_rd, rsp_err, store_err
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    output mem_data, rsp_ready,
    input  req_ready, mem_addr, mem_wmask, mem_wdata,
    input  rsp_valid, rsp_data, rsp_rd, rsp_err, store_err
  );

endinterface

// File: rtl/mem_lsu_align.sv
// Purely combinational byte-lane datapath for the load/store unit.
// Store side: byte-enable mask and lane-replicated write data.
// Load side : byte/halfword extraction plus sign/zero extension.
// Ports:
//   i_stFunct3/i_stAddrLo/i_stData -> o_stMask, o_stData, o_stErr
//   i_ldFunct3/i_ldAddrLo/i_ldRaw  -> o_ldData, o_ldErr
// An erroneous access yields a zero mask / zero load data.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_stFunct3,
  input  logic [1:0]  i_stAddrLo,
  input  logic [31:0] i_stData,
  output logic [3:0]  o_stMask,
  output logic [31:0] o_stData,
  output logic        o_stErr,
  input  logic [2:0]  i_ldFunct3,
  input  logic [1:0]  i_ldAddrLo,
  input  logic [31:0] i_ldRaw,
  output logic [31:0] o_ldData,
  output logic        o_ldErr
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Selected byte / halfword lane of the raw memory word
  assign w_byte = 8'(i_ldRaw >> {i_ldAddrLo, 3'b000});
  assign w_half = 16'(i_ldRaw >> {i_ldAddrLo[1], 4'b0000});

  // Store mask and data: replicating the data across lanes lets the
  // mask alone pick which bytes of the word get written.
  always_comb begin
    o_stErr  = stBad(i_stFunct3, i_stAddrLo);
    o_stMask = 4'b0000;
    o_stData = i_stData;
    case (i_stFunct3)
      F3_B: begin
        o_stMask = 4'b0001 << i_stAddrLo;
        o_stData = {4{i_stData[7:0]}};
      end
      F3_H: begin
        o_stMask = 4'b0011 << i_stAddrLo;
        o_stData = {2{i_stData[15:0]}};
      end
      F3_W:    o_stMask = 4'b1111;
      default: o_stMask = 4'b0000;
    endcase
    if (o_stErr) o_stMask = 4'b0000;
  end

  // Load extraction and extension; bad loads return zero
  always_comb begin
    o_ldErr  = ldBad(i_ldFunct3, i_ldAddrLo);
    o_ldData = '0;
    case (i_ldFunct3)
      F3_B:    o_ldData = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_ldData = {24'b0, w_byte};
      F3_H:    o_ldData = {{16{w_half[15]}}, w_half};
      F3_HU:   o_ldData = {16'b0, w_half};
      F3_W:    o_ldData = i_ldRaw;
      default: o_ldData = '0;
    endcase
    if (o_ldErr) o_ldData = '0;
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit between an in-order core and a data memory with a
// registered (one-cycle) read port.
// Ports:
//   clk, reset : single clock, synchronous active-high reset
//   lsu        : mem_lsu_if.slave (request, memory port, response)
// Stores write in the cycle they are accepted. Loads flow through a
// one-entry stage (p1) that waits for the read data, then into the
// response register; one load per cycle when the consumer keeps up.
module mem_lsu
  import lsu_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  mem_lsu_if.slave lsu
);

  lsu_req_t    w_req;
  lsu_p1_t     r_p1;
  lsu_rsp_t    r_rsp;
  logic        r_p1Valid;
  logic        r_rspValid;
  logic        r_storeErr;

  logic        w_slotFree;
  logic        w_reqReady;
  logic        w_accept;
  logic        w_storeGo;
  logic        w_loadGo;
  logic        w_p1Move;
  logic [3:0]  w_stMask;
  logic [31:0] w_stData;
  logic        w_stErr;
  logic [31:0] w_ldData;
  logic        w_ldErr;

  assign w_req = '{we:     lsu.req_we,
                   funct3: lsu.req_funct3,
                   addr:   lsu.req_addr,
                   wdata:  lsu.req_wdata,
                   rd:     lsu.req_rd};

  // A new request fits if p1 is empty or p1 drains this cycle; while
  // reset is held nothing is taken.
  assign w_slotFree = !r_rspValid || lsu.rsp_ready;
  assign w_reqReady = !reset && (!r_p1Valid || w_slotFree);
  assign w_accept   = lsu.req_valid && w_reqReady;
  assign w_storeGo  = w_accept && w_req.we;
  assign w_loadGo   = w_accept && !w_req.we;
  assign w_p1Move   = r_p1Valid && w_slotFree;

  lsu_align u_align (
    .i_stFunct3 (w_req.funct3),
    .i_stAddrLo (w_req.addr[1:0]),
    .i_stData   (w_req.wdata),
    .o_stMask   (w_stMask),
    .o_stData   (w_stData),
    .o_stErr    (w_stErr),
    .i_ldFunct3 (r_p1.funct3),
    .i_ldAddrLo (r_p1.addr[1:0]),
    .i_ldRaw    (lsu.mem_data),
    .o_ldData   (w_ldData),
    .o_ldErr    (w_ldErr)
  );

  // While p1 is stalled the port keeps pointing at its address so the
  // memory re-reads it every cycle and the data is fresh on release.
  assign lsu.req_ready = w_reqReady;
  assign lsu.mem_addr  = w_accept ? w_req.addr : r_p1.addr;
  assign lsu.mem_wmask = w_storeGo ? w_stMask : 4'b0000;
  assign lsu.mem_wdata = w_storeGo ? w_stData : 32'h0;
  assign lsu.rsp_valid = r_rspValid;
  assign lsu.rsp_data  = r_rsp.data;
  assign lsu.rsp_rd    = r_rsp.rd;
  assign lsu.rsp_err   = r_rsp.err;
  assign lsu.store_err = r_storeErr;

  // Pipeline registers: p1 refills from a new load in the same cycle it
  // hands its result to rsp; rsp only changes when empty or consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_p1Valid  <= 1'b0;
      r_p1       <= '0;
      r_rspValid <= 1'b0;
      r_rsp      <= '0;
      r_storeErr <= 1'b0;
    end else begin
      r_storeErr <= w_storeGo && w_stErr;
      if (w_loadGo) begin
        r_p1Valid <= 1'b1;
        r_p1      <= '{funct3: w_req.funct3, addr: w_req.addr, rd: w_req.rd};
      end else if (w_p1Move) begin
        r_p1Valid <= 1'b0;
      end
      if (w_p1Move) begin
        r_rspValid <= 1'b1;
        r_rsp      <= '{data: w_ldData, rd: r_p1.rd, err: w_ldErr};
      end else if (lsu.rsp_ready) begin
        r_rspValid <= 1'b0;
      end
    end
  end

endmodule
